jogador_automatico: RTL and testbench
=====================================

Name: jogador_automatico

Overview:
- Automatic player for jogo_desafio_memoria: drives the game's inputs (jogar, botoes) and responds to its outputs (leds, pronto, ganhou, perdeu, timeout).
- Records each sequence item the game shows on leds, then replays it as timed button presses.
- Repeats every round until the game ends.
- Used on the board as a self-play demo and in benches as a protocol-accurate stimulus source; supports error injection and timeout provocation.

Parameters:
- MAX_JOGADAS, 16, capacity of the capture buffer (entries of 4 bits).
- T_JOGAR, 5, cycles jogar is held high per start.
- T_PRESS, 10, cycles each button value is held on botoes.
- T_GAP, 10, cycles of botoes=0 after each press.
- T_SILENCIO, 2000, consecutive leds==0 cycles (with ≥1 captured item) that mark end of display phase.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- habilitar  in  1  level; a rising edge starts a game.
- injetar_erro  in  1  when 1, the press at index erro_idx is corrupted.
- erro_idx  in  4  replay index (0-based, within the round) to corrupt.
- omitir  in  1  when 1, replay is suppressed (provokes timeout).
- leds  in  4  game sequence display.
- pronto, ganhou, perdeu, timeout  in  1 each  game end flags.
- jogar  out  1  to game.
- botoes  out  4  to game.
- ocupado  out  1  high in every state except INICIAL and FIM.
- fim  out  1  high in FIM.
- resultado  out  2  latched end cause: 00 none, 01 ganhou, 10 perdeu, 11 timeout.
- db_estado  out  4  state encoding.
- db_contagem  out  5  captured item count.
- db_overflow  out  1  sticky; set on capture attempt with buffer full.

Behaviour:
- Reset (reset=0, asynchronous): state INICIAL; jogar=0, botoes=0, ocupado=0, fim=0, resultado=00, db_contagem=0, db_overflow=0; buffer contents don't care.
- State encodings on db_estado: INICIAL 0, PULSO_JOGAR 1, OBSERVA 2, PRESSIONA 3, INTERVALO 4, FIM 15.
- INICIAL: rising edge of habilitar (registered previous value) -> PULSO_JOGAR.
- PULSO_JOGAR: jogar=1 for exactly T_JOGAR cycles -> OBSERVA. Count and silence counter are cleared on entry.
- OBSERVA: botoes=0.
  - A leds transition 0->nonzero (registered previous leds) captures leds into buffer[count] and increments count on the next edge. Non-one-hot values are captured as-is.
  - If count==MAX_JOGADAS, the capture is discarded and db_overflow is set.
  - The silence counter resets on any leds!=0 and increments while leds==0.
  - When silence reaches T_SILENCIO with count≥1: if omitir=0 -> PRESSIONA with replay index=0; otherwise stay in OBSERVA without capturing.
- PRESSIONA: botoes=buffer[idx] for T_PRESS cycles. If injetar_erro=1 and idx==erro_idx, drive buffer[idx] rotated left by 1 instead (0001->0010, 1000->0001). Then -> INTERVALO.
- INTERVALO: botoes=0 for T_GAP cycles. Then idx+1<count -> PRESSIONA at idx+1; otherwise clear count and silence counter -> OBSERVA (next round re-shows the full, longer sequence).
- End detection has priority over all transitions in every state except INICIAL and FIM.
  - ganhou, perdeu or timeout sampled high -> FIM on the next edge; resultado latched in the same edge.
  - Priority for simultaneous flags: timeout > perdeu > ganhou.
  - botoes and jogar are 0 from the first FIM cycle.
- FIM: fim=1; holds until a habilitar rising edge -> PULSO_JOGAR, which clears resultado and db_overflow.
- habilitar edges while ocupado=1 are ignored.
- Asynchronous reset mid-press forces botoes=0 immediately, without waiting for a clock edge.
- All outputs are registered; no combinational path from inputs to botoes or jogar.

Test Plan:
- Reset with habilitar=1 held -> all outputs 0, state stays INICIAL (no edge); release and reassert habilitar -> jogar high exactly 5 cycles.
- Game shows leds=0001 then silence 2000 cycles -> db_contagem=1, botoes=0001 for 10 cycles then 0 for 10; ganhou after full 16-round game -> resultado=01, fim=1.
- Round with sequence 0001,0100,1000 -> three presses in order, each 10 cycles, separated by 10 zero cycles; count returns to 0 after the last gap.
- injetar_erro=1, erro_idx=0, leds showed 1000 -> botoes=0001; game perdeu -> FIM next edge, resultado=10, botoes=0.
- omitir=1 after first item -> botoes stays 0; game timeout -> resultado=11; timeout and perdeu asserted together -> resultado=11.
- Bench drives 17 captures in one round -> db_contagem=16, db_overflow=1; reset asserted during PRESSIONA -> botoes=0 before next clock edge.

Source files
------------

// File: rtl/jogador_automatico.sv
// Automatic player for jogo_desafio_memoria: captures the sequence shown on
// leds and replays it as timed button presses until the game reports an end.
module jogador_automatico #(
  parameter int MAX_JOGADAS = 16,
  parameter int T_JOGAR     = 5,
  parameter int T_PRESS     = 10,
  parameter int T_GAP       = 10,
  parameter int T_SILENCIO  = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic       injetar_erro,
  input  logic [3:0] erro_idx,
  input  logic       omitir,
  input  logic [3:0] leds,
  input  logic       pronto,
  input  logic       ganhou,
  input  logic       perdeu,
  input  logic       timeout,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       fim,
  output logic [1:0] resultado,
  output logic [3:0] db_estado,
  output logic [4:0] db_contagem,
  output logic       db_overflow
);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PULSO_JOGAR = 4'd1,
    OBSERVA     = 4'd2,
    PRESSIONA   = 4'd3,
    INTERVALO   = 4'd4,
    FIM         = 4'd15
  } estado_t;

  localparam int SW = $clog2(T_SILENCIO + 1);

  estado_t       estado, estado_prox;
  logic          hab_ant;
  logic [3:0]    leds_ant;
  logic [15:0]   timer, timer_prox;
  logic [SW-1:0] silencio, silencio_prox;
  logic [4:0]    contagem, contagem_prox;
  logic [3:0]    idx, idx_prox;
  logic [1:0]    resultado_prox;
  logic          overflow_prox;
  logic          jogar_prox;
  logic [3:0]    botoes_prox;
  logic [3:0]    item;
  logic          captura;
  logic          hab_borda;
  logic          fim_jogo;
  logic          silencio_cheio;
  logic [3:0]    buffer [MAX_JOGADAS];

  // pronto always accompanies the other end flags, so it carries no extra information
  logic unused_pronto;
  assign unused_pronto = pronto;

  assign hab_borda      = habilitar & ~hab_ant;
  assign fim_jogo       = ganhou | perdeu | timeout;
  assign silencio_cheio = (silencio == SW'(T_SILENCIO)) && (contagem != 5'd0);

  assign ocupado     = (estado != INICIAL) && (estado != FIM);
  assign fim         = (estado == FIM);
  assign db_estado   = estado;
  assign db_contagem = contagem;

  always_comb begin
    estado_prox    = estado;
    timer_prox     = timer;
    silencio_prox  = silencio;
    contagem_prox  = contagem;
    idx_prox       = idx;
    resultado_prox = resultado;
    overflow_prox  = db_overflow;
    captura        = 1'b0;
    jogar_prox     = 1'b0;
    botoes_prox    = 4'd0;
    item           = 4'd0;

    case (estado)
      INICIAL, FIM: begin
        if (hab_borda) begin
          estado_prox    = PULSO_JOGAR;
          timer_prox     = 16'd0;
          contagem_prox  = 5'd0;
          silencio_prox  = '0;
          resultado_prox = 2'b00;
          overflow_prox  = 1'b0;
        end
      end
      PULSO_JOGAR: begin
        timer_prox = timer + 16'd1;
        if (timer == 16'(T_JOGAR - 1)) begin
          estado_prox = OBSERVA;
          timer_prox  = 16'd0;
        end
      end
      OBSERVA: begin
        if (leds != 4'd0)
          silencio_prox = '0;
        else if (silencio != SW'(T_SILENCIO))
          silencio_prox = silencio + SW'(1);
        if ((leds_ant == 4'd0) && (leds != 4'd0)) begin
          if (contagem == 5'(MAX_JOGADAS))
            overflow_prox = 1'b1;
          else begin
            captura       = 1'b1;
            contagem_prox = contagem + 5'd1;
          end
        end
        if (silencio_cheio && !omitir) begin
          estado_prox = PRESSIONA;
          idx_prox    = 4'd0;
          timer_prox  = 16'd0;
        end
      end
      PRESSIONA: begin
        timer_prox = timer + 16'd1;
        if (timer == 16'(T_PRESS - 1)) begin
          estado_prox = INTERVALO;
          timer_prox  = 16'd0;
        end
      end
      INTERVALO: begin
        timer_prox = timer + 16'd1;
        if (timer == 16'(T_GAP - 1)) begin
          timer_prox = 16'd0;
          if (({1'b0, idx} + 5'd1) < contagem) begin
            estado_prox = PRESSIONA;
            idx_prox    = idx + 4'd1;
          end else begin
            // the game re-shows the whole, longer sequence next round
            estado_prox   = OBSERVA;
            contagem_prox = 5'd0;
            silencio_prox = '0;
          end
        end
      end
      default: estado_prox = INICIAL;
    endcase

    if (ocupado && fim_jogo) begin
      estado_prox = FIM;
      if (timeout)
        resultado_prox = 2'b11;
      else if (perdeu)
        resultado_prox = 2'b10;
      else
        resultado_prox = 2'b01;
    end

    // outputs are computed for the upcoming state so they leave on a register
    jogar_prox = (estado_prox == PULSO_JOGAR);
    if (estado_prox == PRESSIONA) begin
      item = buffer[idx_prox];
      if (injetar_erro && (idx_prox == erro_idx))
        botoes_prox = {item[2:0], item[3]};
      else
        botoes_prox = item;
    end
  end

  // hab_ant resets high so habilitar held through reset is not seen as an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= INICIAL;
      hab_ant     <= 1'b1;
      leds_ant    <= 4'd0;
      timer       <= 16'd0;
      silencio    <= '0;
      contagem    <= 5'd0;
      idx         <= 4'd0;
      resultado   <= 2'b00;
      db_overflow <= 1'b0;
      jogar       <= 1'b0;
      botoes      <= 4'd0;
    end else begin
      estado      <= estado_prox;
      hab_ant     <= habilitar;
      leds_ant    <= leds;
      timer       <= timer_prox;
      silencio    <= silencio_prox;
      contagem    <= contagem_prox;
      idx         <= idx_prox;
      resultado   <= resultado_prox;
      db_overflow <= overflow_prox;
      jogar       <= jogar_prox;
      botoes      <= botoes_prox;
    end
  end

  always_ff @(posedge clock) begin
    if (captura)
      buffer[contagem[3:0]] <= leds;
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: start pulse, capture/replay timing,
// error injection, omission, end-flag priority, overflow and async reset.
module tb_jogador_automatico;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilitar;
  logic       injetar_erro;
  logic [3:0] erro_idx;
  logic       omitir;
  logic [3:0] leds;
  logic       pronto, ganhou, perdeu, timeout;
  logic       jogar;
  logic [3:0] botoes;
  logic       ocupado;
  logic       fim;
  logic [1:0] resultado;
  logic [3:0] db_estado;
  logic [4:0] db_contagem;
  logic       db_overflow;

  int checks = 0;
  int errors = 0;

  jogador_automatico dut (
    .clock       (clock),
    .reset       (reset),
    .habilitar   (habilitar),
    .injetar_erro(injetar_erro),
    .erro_idx    (erro_idx),
    .omitir      (omitir),
    .leds        (leds),
    .pronto      (pronto),
    .ganhou      (ganhou),
    .perdeu      (perdeu),
    .timeout     (timeout),
    .jogar       (jogar),
    .botoes      (botoes),
    .ocupado     (ocupado),
    .fim         (fim),
    .resultado   (resultado),
    .db_estado   (db_estado),
    .db_contagem (db_contagem),
    .db_overflow (db_overflow)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called on the first cycle of a press; measures press and gap lengths
  task automatic expect_press(input string tag, input logic [3:0] val);
    int n = 0;
    int g = 0;
    while (botoes === val && db_estado === 4'd3 && n < 40) begin
      n++;
      tick();
    end
    check_output({tag, "_press_len"}, 8'(n), 8'd10);
    while (botoes === 4'd0 && db_estado === 4'd4 && g < 40) begin
      g++;
      tick();
    end
    check_output({tag, "_gap_len"}, 8'(g), 8'd10);
  endtask

  task automatic restart();
    habilitar = 1'b0;
    tick();
    habilitar = 1'b1;
    tick();
    check_output("restart_clears_resultado", 8'(resultado), 8'd0);
    tick(5);
    check_output("restart_observa", 8'(db_estado), 8'd2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int n;
    reset        = 1'b0;
    habilitar    = 1'b1;
    injetar_erro = 1'b0;
    erro_idx     = 4'd0;
    omitir       = 1'b0;
    leds         = 4'd0;
    pronto       = 1'b0;
    ganhou       = 1'b0;
    perdeu       = 1'b0;
    timeout      = 1'b0;
    tick(3);
    check_output("rst_jogar",     8'(jogar),       8'd0);
    check_output("rst_botoes",    8'(botoes),      8'd0);
    check_output("rst_ocupado",   8'(ocupado),     8'd0);
    check_output("rst_fim",       8'(fim),         8'd0);
    check_output("rst_resultado", 8'(resultado),   8'd0);
    check_output("rst_estado",    8'(db_estado),   8'd0);
    check_output("rst_contagem",  8'(db_contagem), 8'd0);
    check_output("rst_overflow",  8'(db_overflow), 8'd0);

    reset = 1'b1;
    tick(3);
    check_output("held_hab_no_start", 8'(db_estado), 8'd0);

    habilitar = 1'b0;
    tick();
    habilitar = 1'b1;
    n = 0;
    repeat (20) begin
      tick();
      if (jogar === 1'b1) n++;
    end
    check_output("jogar_len", 8'(n), 8'd5);
    check_output("after_jogar_observa", 8'(db_estado), 8'd2);

    // round 1: single item
    leds = 4'b0001;
    tick(3);
    leds = 4'b0000;
    tick(2000);
    check_output("r1_silence_botoes", 8'(botoes), 8'd0);
    check_output("r1_contagem", 8'(db_contagem), 8'd1);
    check_output("r1_still_observa", 8'(db_estado), 8'd2);
    tick();
    check_output("r1_first_press", 8'(botoes), 8'd1);
    expect_press("r1_p0", 4'b0001);
    check_output("r1_back_observa", 8'(db_estado), 8'd2);
    check_output("r1_contagem_clear", 8'(db_contagem), 8'd0);

    // round 2: three items
    leds = 4'b0001; tick(2);
    leds = 4'b0000; tick(2);
    leds = 4'b0100; tick(2);
    leds = 4'b0000; tick(2);
    leds = 4'b1000; tick(2);
    leds = 4'b0000; tick();
    check_output("r2_contagem", 8'(db_contagem), 8'd3);
    tick(2000);
    check_output("r2_first_press", 8'(botoes), 8'd1);
    expect_press("r2_p0", 4'b0001);
    expect_press("r2_p1", 4'b0100);
    expect_press("r2_p2", 4'b1000);
    check_output("r2_back_observa", 8'(db_estado), 8'd2);
    check_output("r2_contagem_clear", 8'(db_contagem), 8'd0);

    ganhou = 1'b1; tick(); ganhou = 1'b0;
    check_output("win_estado", 8'(db_estado), 8'd15);
    check_output("win_resultado", 8'(resultado), 8'd1);
    check_output("win_fim", 8'(fim), 8'd1);
    check_output("win_ocupado", 8'(ocupado), 8'd0);

    // error injection on index 0
    restart();
    injetar_erro = 1'b1;
    erro_idx     = 4'd0;
    leds = 4'b1000; tick(2);
    leds = 4'b0000; tick(2001);
    check_output("err_rotated", 8'(botoes), 8'd1);
    check_output("err_pressiona", 8'(db_estado), 8'd3);
    tick(3);
    perdeu = 1'b1; tick(); perdeu = 1'b0;
    injetar_erro = 1'b0;
    check_output("lose_estado", 8'(db_estado), 8'd15);
    check_output("lose_resultado", 8'(resultado), 8'd2);
    check_output("lose_botoes", 8'(botoes), 8'd0);
    check_output("lose_jogar", 8'(jogar), 8'd0);

    // omission provokes timeout
    restart();
    leds = 4'b0010; tick(2);
    leds = 4'b0000;
    omitir = 1'b1;
    tick(2100);
    check_output("omit_botoes", 8'(botoes), 8'd0);
    check_output("omit_observa", 8'(db_estado), 8'd2);
    timeout = 1'b1; tick(); timeout = 1'b0;
    omitir = 1'b0;
    check_output("timeout_resultado", 8'(resultado), 8'd3);
    check_output("timeout_fim", 8'(fim), 8'd1);

    restart();
    timeout = 1'b1; perdeu = 1'b1; tick(); timeout = 1'b0; perdeu = 1'b0;
    check_output("prio_timeout_perdeu", 8'(resultado), 8'd3);
    restart();
    perdeu = 1'b1; ganhou = 1'b1; tick(); perdeu = 1'b0; ganhou = 1'b0;
    check_output("prio_perdeu_ganhou", 8'(resultado), 8'd2);

    // overflow and async reset mid-press
    restart();
    check_output("ovf_cleared", 8'(db_overflow), 8'd0);
    for (int i = 0; i < 17; i++) begin
      leds = 4'(1 << (i % 4));
      tick();
      leds = 4'b0000;
      tick();
    end
    check_output("ovf_contagem", 8'(db_contagem), 8'd16);
    check_output("ovf_flag", 8'(db_overflow), 8'd1);
    tick(2000);
    check_output("ovf_pressiona", 8'(db_estado), 8'd3);
    check_output("ovf_first_press", 8'(botoes), 8'd1);
    tick(3);
    #2 reset = 1'b0;
    #1;
    check_output("async_rst_botoes", 8'(botoes), 8'd0);
    check_output("async_rst_estado", 8'(db_estado), 8'd0);
    check_output("async_rst_overflow", 8'(db_overflow), 8'd0);
    check_output("async_rst_contagem", 8'(db_contagem), 8'd0);
    tick(2);
    reset = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
